// File: rtl/vth_read_detector.sv
// vth_read_detector: hard-decision read stage for the NVM channel model.
// Each valid distorted word carries a programmed-cell Vth (unsigned, [31:16])
// and an erased-cell Vth (signed, [15:0]), both Q5.11. Each cell is compared
// against the latched read reference, and raw bit errors are counted over a
// frame of FRAME_LEN words.
// Optional feature macro: VTH_STATS_EN. When it is defined, the stage tracks
// the per-frame minimum programmed Vth and maximum erased Vth. When it is not
// defined, both statistics ports read 0.
//
// Handshake: in_valid is a push-only strobe with no ready. The stage accepts
// a word on every cycle in_valid is high. det_valid is likewise a one-cycle
// strobe, and the consumer must take det_bits on the cycle it is asserted.
module vth_read_detector #(
  parameter int                 FRAME_LEN    = 1024,
  parameter int                 CNT_W        = 16,
  parameter logic signed [15:0] VREF_DEFAULT = 16'sd2048
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      vref_i,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             det_valid,
  output logic [1:0]       det_bits,
  output logic [CNT_W-1:0] err_prog_cnt,
  output logic [CNT_W-1:0] err_erase_cnt,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      prog_vth_min,
  output logic [15:0]      erase_vth_max,
  output logic [1:0]       dbgState
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t            state;
  state_t            stateNext;
  logic [15:0]       vrefQ;
  logic [15:0]       vrefSel;
  logic [CNT_W-1:0]  wordCnt;
  logic [CNT_W-1:0]  errProg;
  logic [CNT_W-1:0]  errErase;
  logic              detValidQ;
  logic [1:0]        detBitsQ;
  logic signed [16:0] progV;
  logic signed [16:0] eraseV;
  logic signed [16:0] vrefX;
  logic              progBit;
  logic              eraseBit;
  logic              startEn;
  logic              countEn;

  // Programmed Vth is unsigned, so it is widened with a zero. The erased Vth
  // and the reference are widened with their sign bits. A 17-bit signed
  // compare then orders all three correctly.
  assign progV    = {1'b0, in_data[31:16]};
  assign eraseV   = {in_data[15], in_data[15:0]};
  assign vrefX    = {vrefQ[15], vrefQ};
  assign progBit  = (progV < vrefX);
  assign eraseBit = (eraseV < vrefX);

  assign vrefSel  = (vref_i == 16'd0) ? VREF_DEFAULT : vref_i;
  assign startEn  = (state == IDLE) && start;
  assign countEn  = (state == RUN) && in_valid;

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode: open on start, close after the last counted word.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RUN;
      RUN:     if (in_valid && (wordCnt == LAST_IDX)) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Detection pipeline: one-cycle registered hard decisions on every valid word.
  always_ff @(posedge clk) begin
    if (reset) begin
      detValidQ <= 1'b0;
      detBitsQ  <= 2'b00;
    end else begin
      detValidQ <= in_valid;
      detBitsQ  <= {progBit, eraseBit};
    end
  end

  // Frame bookkeeping: latch the reference and clear on start, then count words and saturating errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      vrefQ    <= VREF_DEFAULT;
      wordCnt  <= '0;
      errProg  <= '0;
      errErase <= '0;
    end else if (startEn) begin
      vrefQ    <= vrefSel;
      wordCnt  <= '0;
      errProg  <= '0;
      errErase <= '0;
    end else if (countEn) begin
      wordCnt <= wordCnt + CNT_W'(1);
      if (progBit && (errProg != CNT_MAX)) begin
        errProg <= errProg + CNT_W'(1);
      end
      if (!eraseBit && (errErase != CNT_MAX)) begin
        errErase <= errErase + CNT_W'(1);
      end
    end
  end

`ifdef VTH_STATS_EN
  logic [15:0] progMin;
  logic [15:0] eraseMax;

  // Per-frame extremes over counted words. They use the same timing as the error counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      progMin  <= 16'h0000;
      eraseMax <= 16'h0000;
    end else if (startEn) begin
      progMin  <= 16'hFFFF;
      eraseMax <= 16'h8000;
    end else if (countEn) begin
      if (in_data[31:16] < progMin) begin
        progMin <= in_data[31:16];
      end
      if ($signed(in_data[15:0]) > $signed(eraseMax)) begin
        eraseMax <= in_data[15:0];
      end
    end
  end

  assign prog_vth_min  = progMin;
  assign erase_vth_max = eraseMax;
`else
  assign prog_vth_min  = 16'h0000;
  assign erase_vth_max = 16'h0000;
`endif

  assign det_valid     = detValidQ;
  assign det_bits      = detBitsQ;
  assign err_prog_cnt  = errProg;
  assign err_erase_cnt = errErase;
  assign busy          = (state == RUN);
  assign frame_done    = (state == DONE);
  assign dbgState      = state;

endmodule

// File: tb/tb_vth_read_detector.sv
// tb_vth_read_detector: directed bench for vth_read_detector.
// The design runs with a short frame and narrow counters so that frame
// boundaries and saturation are both reached.
module tb_vth_read_detector;

  localparam int FRAME_LEN = 4;
  localparam int CNT_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int VREF_DEF  = 2048;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [15:0]      vref_i;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             det_valid;
  logic [1:0]       det_bits;
  logic [CNT_W-1:0] err_prog_cnt;
  logic [CNT_W-1:0] err_erase_cnt;
  logic             busy;
  logic             frame_done;
  logic [15:0]      prog_vth_min;
  logic [15:0]      erase_vth_max;
  logic [1:0]       dbgState;

  always #5 clk = ~clk;

  vth_read_detector #(
    .FRAME_LEN    (FRAME_LEN),
    .CNT_W        (CNT_W),
    .VREF_DEFAULT (16'sd2048)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .vref_i        (vref_i),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .det_valid     (det_valid),
    .det_bits      (det_bits),
    .err_prog_cnt  (err_prog_cnt),
    .err_erase_cnt (err_erase_cnt),
    .busy          (busy),
    .frame_done    (frame_done),
    .prog_vth_min  (prog_vth_min),
    .erase_vth_max (erase_vth_max),
    .dbgState      (dbgState)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int nCompared = 0;
  int nMismatch = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model describes a frame as "open" or "closing" and counts words with
  // integers. Vth values are compared as plain integers.
  logic [1:0] exp_q[$];
  bit  modelLive = 0;
  bit  mInFrame  = 0;
  bit  mClosing  = 0;
  int  mVref     = VREF_DEF;
  int  mWords    = 0;
  int  mErrP     = 0;
  int  mErrE     = 0;
  int  mMin      = 0;
  int  mMax      = 0;

  // Model update on the same edges as the DUT.
  always @(posedge clk) begin : model
    int pv;
    int ev;
    bit pBit;
    bit eBit;
    logic signed [15:0] eraseS;
    logic signed [15:0] vrefS;
    if (reset) begin
      exp_q.delete();
      modelLive = 1;
      mInFrame  = 0;
      mClosing  = 0;
      mVref     = VREF_DEF;
      mWords    = 0;
      mErrP     = 0;
      mErrE     = 0;
      mMin      = 0;
      mMax      = 0;
    end else begin
      pv     = int'(in_data[31:16]);
      eraseS = in_data[15:0];
      ev     = int'(eraseS);
      pBit   = (pv < mVref);
      eBit   = (ev < mVref);
      if (in_valid) exp_q.push_back({pBit, eBit});
      if (mClosing) begin
        mClosing = 0;
      end else if (mInFrame) begin
        if (in_valid) begin
          mErrP = (mErrP + int'(pBit) > CNT_MAX) ? CNT_MAX : mErrP + int'(pBit);
          mErrE = (mErrE + int'(!eBit) > CNT_MAX) ? CNT_MAX : mErrE + int'(!eBit);
          if (pv < mMin) mMin = pv;
          if (ev > mMax) mMax = ev;
          mWords++;
          if (mWords == FRAME_LEN) begin
            mInFrame = 0;
            mClosing = 1;
          end
        end
      end else if (start) begin
        vrefS    = vref_i;
        mInFrame = 1;
        mWords   = 0;
        mErrP    = 0;
        mErrE    = 0;
        mMin     = 65535;
        mMax     = -32768;
        mVref    = (vref_i == 16'd0) ? VREF_DEF : int'(vrefS);
      end
    end
  end

  // Compare process: check all outputs against the model every cycle.
  always @(negedge clk) begin : compare
    logic [1:0]  e;
    logic [15:0] expMin;
    logic [15:0] expMax;
    bit          expV;
    if (modelLive) begin
      expV = (exp_q.size() != 0);
      cmp("det_valid", 32'(det_valid), 32'(expV));
      if (expV) begin
        e = exp_q.pop_front();
        if (det_valid) cmp("det_bits", 32'(det_bits), 32'(e));
      end
      cmp("err_prog_cnt", 32'(err_prog_cnt), 32'(mErrP));
      cmp("err_erase_cnt", 32'(err_erase_cnt), 32'(mErrE));
      cmp("busy", 32'(busy), 32'(mInFrame));
      cmp("frame_done", 32'(frame_done), 32'(mClosing));
`ifdef VTH_STATS_EN
      expMin = 16'(mMin);
      expMax = 16'(mMax);
`else
      expMin = 16'h0000;
      expMax = 16'h0000;
`endif
      cmp("prog_vth_min", 32'(prog_vth_min), 32'(expMin));
      cmp("erase_vth_max", 32'(erase_vth_max), 32'(expMax));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic sendWord(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic pulseStart(input logic [15:0] v);
    start  = 1'b1;
    vref_i = v;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    vref_i   = 16'h0000;
    in_valid = 1'b0;
    in_data  = 32'h0;
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_det_valid", 32'(det_valid), 32'd0);
    cmp("rst_err_prog", 32'(err_prog_cnt), 32'd0);
    cmp("rst_frame_done", 32'(frame_done), 32'd0);
    idle(1);

    // Frame 1: default reference, clean cells.
    pulseStart(16'h0000);
    for (int i = 0; i < 4; i++) sendWord(32'h1C00_F800);
    @(negedge clk);
    cmp("f1_frame_done", 32'(frame_done), 32'd1);
    cmp("f1_det_bits", 32'(det_bits), 32'd1);
    cmp("f1_err_prog", 32'(err_prog_cnt), 32'd0);
    cmp("f1_err_erase", 32'(err_erase_cnt), 32'd0);
    idle(1);

    // Frame 2: two words fail both cells. A word in the DONE cycle is not counted.
    pulseStart(16'h0000);
    sendWord(32'h1C00_F800);
    sendWord(32'h0000_0900);
    sendWord(32'h0000_0900);
    sendWord(32'h1C00_F800);
    @(negedge clk);
    cmp("f2_frame_done", 32'(frame_done), 32'd1);
    cmp("f2_err_prog", 32'(err_prog_cnt), 32'd2);
    cmp("f2_err_erase", 32'(err_erase_cnt), 32'd2);
    sendWord(32'h0000_0900);
    @(negedge clk);
    cmp("f2_hold_prog", 32'(err_prog_cnt), 32'd2);
    idle(1);

    // Frame 3: a value equal to the reference is not below it.
    pulseStart(16'sd2048);
    sendWord(32'h0800_07FF);
    @(negedge clk);
    cmp("f3_det_bits", 32'(det_bits), 32'd1);
    for (int i = 0; i < 3; i++) sendWord(32'h0800_07FF);
    @(negedge clk);
    cmp("f3_err_prog", 32'(err_prog_cnt), 32'd0);
    cmp("f3_err_erase", 32'(err_erase_cnt), 32'd0);
    idle(1);

    // Frame 4: negative reference (-1.0 V) checks the sign handling.
    pulseStart(16'hF800);
    sendWord(32'h0000_F000);
    sendWord(32'hFFFF_F800);
    sendWord(32'h0000_F801);
    sendWord(32'h7FFF_8000);
    @(negedge clk);
    cmp("f4_err_prog", 32'(err_prog_cnt), 32'd0);
    cmp("f4_err_erase", 32'(err_erase_cnt), 32'd2);
    idle(1);

    // Frame 5: every word fails, so the counters saturate. A start in DONE is ignored.
    pulseStart(16'h0000);
    for (int i = 0; i < 4; i++) sendWord(32'h0000_0900);
    @(negedge clk);
    cmp("f5_frame_done", 32'(frame_done), 32'd1);
    cmp("f5_err_prog_sat", 32'(err_prog_cnt), 32'd3);
    cmp("f5_err_erase_sat", 32'(err_erase_cnt), 32'd3);
    pulseStart(16'h1234);
    @(negedge clk);
    cmp("f5_no_restart", 32'(busy), 32'd0);
    idle(1);

    // Frame 6: start and in_valid arrive in the same cycle; that word is not counted.
    start    = 1'b1;
    vref_i   = 16'h0000;
    in_valid = 1'b1;
    in_data  = 32'h0000_0900;
    @(posedge clk);
    #1;
    start    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) sendWord(32'h1C00_F800);
    @(negedge clk);
    cmp("f6_frame_done", 32'(frame_done), 32'd1);
    cmp("f6_err_prog", 32'(err_prog_cnt), 32'd0);
    idle(1);

    // Frame 7: statistics over the frame.
    pulseStart(16'h0000);
    sendWord(32'h1C00_F800);
    sendWord(32'h1000_FF00);
    sendWord(32'h2000_F000);
    sendWord(32'h1C00_F800);
    @(negedge clk);
`ifdef VTH_STATS_EN
    cmp("f7_prog_min", 32'(prog_vth_min), 32'h1000);
    cmp("f7_erase_max", 32'(erase_vth_max), 32'hFF00);
`else
    cmp("f7_prog_min", 32'(prog_vth_min), 32'h0000);
    cmp("f7_erase_max", 32'(erase_vth_max), 32'h0000);
`endif
    idle(1);

    // Frame 8: a start in RUN is ignored, gaps are allowed, and a reset arrives mid-frame.
    pulseStart(16'h0000);
    sendWord(32'h0000_0900);
    pulseStart(16'h0000);
    idle(3);
    sendWord(32'h0000_0900);
    @(negedge clk);
    cmp("f8_no_restart_prog", 32'(err_prog_cnt), 32'd2);
    cmp("f8_busy", 32'(busy), 32'd1);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h1C00_F800;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    cmp("f8_rst_det_valid", 32'(det_valid), 32'd0);
    cmp("f8_rst_busy", 32'(busy), 32'd0);
    cmp("f8_rst_err_prog", 32'(err_prog_cnt), 32'd0);
    cmp("f8_rst_frame_done", 32'(frame_done), 32'd0);
    idle(6);

    cmp("det_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
